// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, transaction status codes and the
// IN-transaction sequencer state encoding.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_DUP     = 3'd1,
        ST_NAK     = 3'd2,
        ST_STALL   = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_ERR     = 3'd5
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TOKEN    = 3'd1,
        S_LISTEN   = 3'd2,
        S_CHECK    = 3'd3,
        S_SEND_ACK = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_timeout_ctr.sv
// LISTEN-window timer: synchronous clear, count enable, saturates instead of
// wrapping; tc flags the last cycle of a TIMEOUT_CYC-long window.
module usb_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != W'(TIMEOUT_CYC))) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/usb_in_xact_ctrl.sv
// Host IN-transaction sequencer: token, listen window, packet judgement,
// ACK and retry. Define USB_IN_TOGGLE_CHK_EN to enable DATA0/DATA1 duplicate detection.
module usb_in_xact_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic       toggle_clr,
    output logic       tok_req,
    input  logic       tok_done,
    output logic       dec_en,
    input  logic       dec_pkt_avail,
    input  logic       dec_valid,
    input  logic       dec_crc_ok,
    input  logic [3:0] dec_pid,
    output logic       hs_req,
    output logic [3:0] hs_pid,
    input  logic       hs_done,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    output logic       exp_toggle,
    output state_t     state_dbg
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t        state, state_nxt;
    status_t       status_q;
    logic [RW-1:0] retry_cnt;
    logic [3:0]    pid_q;
    logic          valid_q;
    logic          crc_q;
    logic          exp_toggle_q;

    logic timer_tc;
    logic chk_fail;
    logic chk_nak;
    logic chk_stall;
    logic toggle_ok;
    logic listen_timeout;
    logic attempt_fail;
    logic can_retry;

    usb_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk  (clk),
        .rst_b(rst_b),
        .clr  (state == S_TOKEN),
        .en   (state == S_LISTEN),
        .tc   (timer_tc)
    );

    // Packet judgement on the registered decoder fields; a bad PID check or
    // a corrupt data payload outranks every PID decision.
    assign chk_fail  = !valid_q
                    || (is_data_pid(pid_q) && !crc_q)
                    || !(is_data_pid(pid_q) || (pid_q == PID_NAK) || (pid_q == PID_STALL));
    assign chk_nak   = (pid_q == PID_NAK);
    assign chk_stall = (pid_q == PID_STALL);

`ifdef USB_IN_TOGGLE_CHK_EN
    assign toggle_ok = ((pid_q == PID_DATA1) == exp_toggle_q);
`else
    assign toggle_ok = 1'b1;
`endif

    // A packet arriving on the final window cycle beats the timeout.
    assign listen_timeout = (state == S_LISTEN) && !dec_pkt_avail && timer_tc;
    assign attempt_fail   = listen_timeout || ((state == S_CHECK) && chk_fail);
    assign can_retry      = (retry_cnt < RETRY_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_TOKEN;
            end
            S_TOKEN: begin
                if (tok_done) state_nxt = S_LISTEN;
            end
            S_LISTEN: begin
                if (dec_pkt_avail)       state_nxt = S_CHECK;
                else if (listen_timeout) state_nxt = can_retry ? S_TOKEN : S_DONE;
            end
            S_CHECK: begin
                if (chk_fail)                  state_nxt = can_retry ? S_TOKEN : S_DONE;
                else if (chk_nak || chk_stall) state_nxt = S_DONE;
                else                           state_nxt = S_SEND_ACK;
            end
            S_SEND_ACK: begin
                if (hs_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tok_req   = (state == S_TOKEN);
        dec_en    = (state == S_LISTEN);
        hs_req    = (state == S_SEND_ACK);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        hs_pid    = PID_ACK;
        status    = status_q;
        exp_toggle = exp_toggle_q;
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            status_q     <= ST_OK;
            retry_cnt    <= '0;
            exp_toggle_q <= 1'b0;
            pid_q        <= 4'h0;
            valid_q      <= 1'b0;
            crc_q        <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                if (toggle_clr) exp_toggle_q <= 1'b0;
                if (start) begin
                    retry_cnt <= '0;
                    status_q  <= ST_OK;
                end
            end

            if ((state == S_LISTEN) && dec_pkt_avail) begin
                pid_q   <= dec_pid;
                valid_q <= dec_valid;
                crc_q   <= dec_crc_ok;
            end

            if (attempt_fail) begin
                if (can_retry) retry_cnt <= retry_cnt + 1'b1;
                else           status_q  <= listen_timeout ? ST_TIMEOUT : ST_ERR;
            end

            if ((state == S_CHECK) && !chk_fail) begin
                if (chk_nak) begin
                    status_q <= ST_NAK;
                end else if (chk_stall) begin
                    status_q <= ST_STALL;
                end else if (toggle_ok) begin
                    status_q     <= ST_OK;
                    exp_toggle_q <= !exp_toggle_q;
                end else begin
                    status_q <= ST_DUP;
                end
            end
        end
    end

endmodule
